// File: rtl/mem_access_stage.sv
// MEM stage controller: issues the dcache request for the EX/MEM op and stalls until dhit.
// It holds the result until the pipeline advances and owns the LL/SC link register.
module mem_access_stage #(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned WDOG_MAX = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              op_valid,
    input  logic              op_read,
    input  logic              op_write,
    input  logic              op_ll,
    input  logic              op_sc,
    input  logic [WORD_W-1:0] op_addr,
    input  logic [WORD_W-1:0] op_wdata,
    input  logic              advance,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] rdata,
    output logic              rdata_vld,
    output logic              wdog_err
);
    localparam int unsigned WDOG_W = $clog2(WDOG_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                link_vld_q, link_vld_d;
    logic [WORD_W-1:0]   link_addr_q, link_addr_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                wdog_err_q, wdog_err_d;

    logic                is_rd, is_wr, is_ll, is_sc;
    logic                mem_op, link_hit, sc_fail;
    logic                issue, sc_reject, done;
    logic [WORD_W-1:0]   result;

    // Read+write together decodes as a read.
    assign is_rd     = op_read;
    assign is_wr     = op_write & ~op_read;
    assign is_ll     = op_ll & is_rd;
    assign is_sc     = op_sc & is_wr;
    assign mem_op    = op_valid & (op_read | op_write);
    assign link_hit  = link_vld_q & (link_addr_q == op_addr);
    assign sc_fail   = is_sc & ~link_hit;
    assign issue     = (state_q == IDLE) & mem_op & ~sc_fail;
    assign sc_reject = (state_q == IDLE) & mem_op & sc_fail;
    assign done      = dhit & (issue | (state_q == ACCESS));
    assign result    = is_rd ? dload : WORD_W'(is_sc);

    always_comb begin
        state_d     = state_q;
        link_vld_d  = link_vld_q;
        link_addr_d = link_addr_q;
        rdata_d     = rdata_q;
        wdog_d      = wdog_q;
        wdog_err_d  = wdog_err_q;

        case (state_q)
            IDLE: begin
                if (issue) begin
                    if (!dhit)        state_d = ACCESS;
                    else if (!advance) state_d = HOLD;
                end
            end
            ACCESS: begin
                if (dhit) state_d = advance ? IDLE : HOLD;
            end
            HOLD: begin
                if (advance) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Diagnostic watchdog; saturates so the sticky flag cannot be missed.
        if (state_q == ACCESS) begin
            if (wdog_q == WDOG_W'(WDOG_MAX)) wdog_err_d = 1'b1;
            if (dhit)                             wdog_d = '0;
            else if (wdog_q != WDOG_W'(WDOG_MAX)) wdog_d = wdog_q + WDOG_W'(1);
        end

        if (done)           rdata_d = result;
        else if (sc_reject) rdata_d = '0;

        // Link register, highest priority first.
        if (snoop_inv && (link_addr_q == snoop_addr)) begin
            link_vld_d = 1'b0;
        end else if ((done && is_sc) || sc_reject) begin
            link_vld_d = 1'b0;
        end else if (done && is_ll) begin
            link_vld_d  = 1'b1;
            link_addr_d = op_addr;
        end else if (done && is_wr && (link_addr_q == op_addr)) begin
            link_vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            link_vld_q  <= 1'b0;
            link_addr_q <= '0;
            rdata_q     <= '0;
            wdog_q      <= '0;
            wdog_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            link_vld_q  <= link_vld_d;
            link_addr_q <= link_addr_d;
            rdata_q     <= rdata_d;
            wdog_q      <= wdog_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    // Request and result outputs; hit cycles forward dload with no added latency.
    always_comb begin
        dREN      = 1'b0;
        dWEN      = 1'b0;
        mem_stall = 1'b0;
        rdata_vld = 1'b0;
        rdata     = '0;
        daddr     = '0;
        dstore    = '0;
        wdog_err  = 1'b0;
        if (!RST) begin
            daddr    = op_addr;
            dstore   = op_wdata;
            wdog_err = wdog_err_q;
            rdata    = rdata_q;
            case (state_q)
                IDLE: begin
                    dREN      = issue & is_rd;
                    dWEN      = issue & is_wr;
                    mem_stall = issue & ~dhit;
                    if (issue && dhit) begin
                        rdata_vld = 1'b1;
                        rdata     = result;
                    end else if (sc_reject) begin
                        rdata_vld = 1'b1;
                        rdata     = '0;
                    end
                end
                ACCESS: begin
                    dREN      = is_rd;
                    dWEN      = is_wr;
                    mem_stall = ~dhit;
                    if (dhit) begin
                        rdata_vld = 1'b1;
                        rdata     = result;
                    end
                end
                HOLD: begin
                    rdata_vld = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_access_stage;
    localparam int unsigned W        = 32;
    localparam int          WDOG_MAX = 255;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         op_valid = 1'b0, op_read = 1'b0, op_write = 1'b0, op_ll = 1'b0, op_sc = 1'b0;
    logic [W-1:0] op_addr = '0, op_wdata = '0;
    logic         advance = 1'b0, dhit = 1'b0, snoop_inv = 1'b0;
    logic [W-1:0] dload = '0, snoop_addr = '0;
    logic         dREN, dWEN, mem_stall, rdata_vld, wdog_err;
    logic [W-1:0] daddr, dstore, rdata;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Model: request outstanding, result held, link, and request age in cycles.
    bit           m_busy = 0, m_done = 0, m_lvld = 0, m_err = 0;
    logic [W-1:0] m_laddr = '0, m_res = '0;
    int           m_age = 0;

    logic         e_dren, e_dwen, e_stall, e_vld;
    logic [W-1:0] e_rdata;

    mem_access_stage #(.WORD_W(W), .WDOG_MAX(WDOG_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .op_valid(op_valid), .op_read(op_read), .op_write(op_write),
        .op_ll(op_ll), .op_sc(op_sc), .op_addr(op_addr), .op_wdata(op_wdata),
        .advance(advance), .dhit(dhit), .dload(dload),
        .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .mem_stall(mem_stall), .rdata(rdata), .rdata_vld(rdata_vld), .wdog_err(wdog_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!RST && op_valid)
            assert (!(op_read && op_write)) else $error("illegal op: read and write together");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit sc_rejected();
        bit wr = op_write && !op_read;
        return op_valid && wr && op_sc && !(m_lvld && m_laddr == op_addr);
    endfunction

    function automatic bit wants_req();
        bit mem = op_valid && (op_read || op_write);
        if (RST || m_done) return 1'b0;
        return m_busy || (mem && !sc_rejected());
    endfunction

    function automatic logic [W-1:0] op_result();
        if (op_read) return dload;
        return (op_write && op_sc) ? W'(1) : W'(0);
    endfunction

    task automatic predict();
        bit mem = op_valid && (op_read || op_write);
        e_dren = 0; e_dwen = 0; e_stall = 0; e_vld = 0; e_rdata = '0;
        if (RST) return;
        if (m_done) begin
            e_vld = 1; e_rdata = m_res;
        end else if (wants_req()) begin
            e_dren  = op_read;
            e_dwen  = op_write && !op_read;
            e_stall = !dhit;
            if (dhit) begin e_vld = 1; e_rdata = op_result(); end
        end else if (mem) begin
            e_vld = 1; e_rdata = '0;
        end
    endtask

    task automatic update();
        bit fresh, completing, rejected, wr, ll, sc;
        if (RST) begin
            m_busy = 0; m_done = 0; m_lvld = 0; m_laddr = '0; m_err = 0; m_age = 0;
            return;
        end
        wr         = op_write && !op_read;
        ll         = op_read && op_ll;
        sc         = wr && op_sc;
        fresh      = !m_busy && !m_done && wants_req();
        rejected   = !m_busy && !m_done && sc_rejected();
        completing = (m_busy || fresh) && dhit;
        if (snoop_inv && m_laddr == snoop_addr)               m_lvld = 0;
        else if ((completing && sc) || rejected)              m_lvld = 0;
        else if (completing && ll) begin m_lvld = 1; m_laddr = op_addr; end
        else if (completing && wr && m_laddr == op_addr)      m_lvld = 0;
        // Issue cycle plus WDOG_MAX+1 waiting cycles trips the watchdog.
        if (m_busy || fresh) m_age++;
        if (m_age >= WDOG_MAX + 2) m_err = 1;
        if (m_done && advance) m_done = 0;
        if (completing) begin
            m_age = 0; m_busy = 0; m_res = op_result(); m_done = !advance;
        end else if (fresh) begin
            m_busy = 1;
        end
    endtask

    task automatic look();
        @(negedge CLK);
        predict();
        chk("dREN", W'(dREN), W'(e_dren));
        chk("dWEN", W'(dWEN), W'(e_dwen));
        chk("mem_stall", W'(mem_stall), W'(e_stall));
        chk("rdata_vld", W'(rdata_vld), W'(e_vld));
        if (e_vld || RST) chk("rdata", rdata, e_rdata);
        chk("daddr", daddr, RST ? '0 : op_addr);
        chk("dstore", dstore, RST ? '0 : op_wdata);
        chk("wdog_err", W'(wdog_err), RST ? '0 : W'(m_err));
    endtask

    task automatic tick();
        update();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_op(input bit v, input bit r, input bit w, input bit ll, input bit sc,
                          input logic [W-1:0] a, input logic [W-1:0] d);
        op_valid = v; op_read = r; op_write = w; op_ll = ll; op_sc = sc;
        op_addr = a; op_wdata = d;
    endtask

    task automatic idle_cycle(input string tag);
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0);
        dhit = 0; advance = 1;
        look();
        chk({tag, "_idle_vld"}, W'(rdata_vld), W'(0));
        chk({tag, "_idle_stall"}, W'(mem_stall), W'(0));
        tick();
    endtask

    function automatic logic [W-1:0] pick_addr();
        case ($urandom_range(3))
            0:       return 32'h100;
            1:       return 32'h104;
            2:       return 32'h200;
            default: return 32'h300;
        endcase
    endfunction

    initial begin
        bit held;
        int kind;

        // Reset with a live op: every output must stay low.
        set_op(1, 1, 0, 0, 0, 32'hABCD, 32'h1234);
        look(); chk("rst_daddr", daddr, 32'h0); chk("rst_dREN", W'(dREN), W'(0)); tick();
        look(); tick();
        RST = 0;

        // 1: LW, hit on the 3rd cycle with advance.
        set_op(1, 1, 0, 0, 0, 32'h40, 32'h0); dhit = 0; advance = 0;
        look(); chk("t1_c1_dREN", W'(dREN), W'(1)); chk("t1_c1_stall", W'(mem_stall), W'(1)); tick();
        look(); chk("t1_c2_dREN", W'(dREN), W'(1)); chk("t1_c2_stall", W'(mem_stall), W'(1)); tick();
        dhit = 1; dload = 32'hDEADBEEF; advance = 1;
        look(); chk("t1_c3_dREN", W'(dREN), W'(1)); chk("t1_c3_stall", W'(mem_stall), W'(0));
        chk("t1_rdata", rdata, 32'hDEADBEEF); tick();
        idle_cycle("t1");

        // 2: LL then SC to the same address succeeds once.
        set_op(1, 1, 0, 1, 0, 32'h100, 32'h0); dhit = 1; dload = 32'h55; advance = 1;
        look(); tick();
        set_op(1, 0, 1, 0, 1, 32'h100, 32'h77);
        look(); chk("t2_sc_dWEN", W'(dWEN), W'(1)); chk("t2_sc_rdata", rdata, 32'h1); tick();
        dhit = 0;
        look(); chk("t2_sc2_dWEN", W'(dWEN), W'(0)); chk("t2_sc2_rdata", rdata, 32'h0);
        chk("t2_sc2_vld", W'(rdata_vld), W'(1)); tick();

        // 3: snoop invalidate kills the link.
        set_op(1, 1, 0, 1, 0, 32'h100, 32'h0); dhit = 1; advance = 1;
        look(); tick();
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0); dhit = 0; snoop_inv = 1; snoop_addr = 32'h100;
        look(); tick();
        snoop_inv = 0;
        set_op(1, 0, 1, 0, 1, 32'h100, 32'h9);
        look(); chk("t3_dWEN", W'(dWEN), W'(0)); chk("t3_rdata", rdata, 32'h0);
        chk("t3_vld", W'(rdata_vld), W'(1)); chk("t3_stall", W'(mem_stall), W'(0)); tick();

        // 4: hit without advance holds the result.
        set_op(1, 1, 0, 0, 0, 32'h80, 32'h0); dhit = 1; dload = 32'h12345678; advance = 0;
        look(); chk("t4_hit_rdata", rdata, 32'h12345678); tick();
        dhit = 0; dload = 32'hCAFEF00D;
        look(); chk("t4_h1_dREN", W'(dREN), W'(0)); chk("t4_h1_rdata", rdata, 32'h12345678); tick();
        advance = 1;
        look(); chk("t4_h2_dREN", W'(dREN), W'(0)); chk("t4_h2_rdata", rdata, 32'h12345678); tick();
        idle_cycle("t4");

        // 5: reset in the middle of an access.
        set_op(1, 1, 0, 1, 0, 32'h200, 32'h0); dhit = 1; advance = 1;
        look(); tick();
        set_op(1, 1, 0, 0, 0, 32'h40, 32'h0); dhit = 0; advance = 0;
        look(); chk("t5_acc_dREN", W'(dREN), W'(1)); tick();
        look(); tick();
        RST = 1;
        look(); chk("t5_rst_dREN", W'(dREN), W'(0)); chk("t5_rst_stall", W'(mem_stall), W'(0)); tick();
        RST = 0;
        idle_cycle("t5");
        set_op(1, 0, 1, 0, 1, 32'h200, 32'h3); dhit = 0; advance = 1;
        look(); chk("t5_sc_dWEN", W'(dWEN), W'(0)); chk("t5_sc_vld", W'(rdata_vld), W'(1)); tick();

        // 6: watchdog trips and stays set until reset.
        set_op(1, 1, 0, 0, 0, 32'h300, 32'h0); dhit = 0; advance = 0;
        for (int i = 1; i <= 300; i++) begin
            look();
            if (i == 257) chk("t6_wdog_before", W'(wdog_err), W'(0));
            if (i == 258) chk("t6_wdog_after", W'(wdog_err), W'(1));
            tick();
        end
        dhit = 1; dload = 32'h600D; advance = 1;
        look(); chk("t6_hit_rdata", rdata, 32'h600D); tick();
        idle_cycle("t6");
        look(); chk("t6_sticky", W'(wdog_err), W'(1)); tick();
        RST = 1; look(); tick();
        RST = 0;
        look(); chk("t6_cleared", W'(wdog_err), W'(0)); tick();

        // Randomized traffic; the op holds until the slot retires.
        held = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!held) begin
                kind = int'($urandom_range(5));
                case (kind)
                    0:       set_op(0, 0, 0, 0, 0, pick_addr(), $urandom);
                    1:       set_op(1, 1, 0, 0, 0, pick_addr(), $urandom);
                    2:       set_op(1, 1, 0, 1, 0, pick_addr(), $urandom);
                    3:       set_op(1, 0, 1, 0, 0, pick_addr(), $urandom);
                    4:       set_op(1, 0, 1, 0, 1, pick_addr(), $urandom);
                    default: set_op(1, 0, 0, 0, 0, pick_addr(), $urandom);
                endcase
                held = 1;
            end
            RST        = ($urandom_range(199) == 0);
            snoop_inv  = ($urandom_range(7) == 0);
            snoop_addr = pick_addr();
            dload      = $urandom;
            dhit       = wants_req() ? ($urandom_range(2) == 0) : 1'b0;
            advance    = (wants_req() && !dhit) ? 1'b0 : 1'($urandom_range(1));
            look();
            tick();
            if (advance || RST) held = 0;
        end
        RST = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
